// File: rtl/mem_responder_2port.sv
// mem_responder_2port: word memory answering the val/wait request protocol on two ports (0 = fetch, 1 = data).
// Latency: LATENCY wait cycles per transaction; MEM_RESPONDER_STALL_RAND_EN adds 0..3 pseudo-random extra cycles.
// Backpressure: wait stays high until the completion cycle; dropping val while busy aborts with no write.
module mem_responder_2port #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 0,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem0_val,
  output logic        mem0_wait,
  input  logic        mem0_type,
  input  logic [31:0] mem0_addr,
  input  logic [31:0] mem0_wdata,
  output logic [31:0] mem0_rdata,
  input  logic        mem1_val,
  output logic        mem1_wait,
  input  logic        mem1_type,
  input  logic [31:0] mem1_addr,
  input  logic [31:0] mem1_wdata,
  output logic [31:0] mem1_rdata,
  input  logic        init_en,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_wdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
`ifdef MEM_RESPONDER_STALL_RAND_EN
  localparam int CNT_W = 5;  // LATENCY plus up to 3 random cycles can exceed 15
`else
  localparam int CNT_W = 4;
`endif
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [31:0]          mem [DEPTH];
  state_t               state_q [2];
  state_t               state_d [2];
  logic [CNT_W-1:0]     cnt_q   [2];
  logic [CNT_W-1:0]     cnt_d   [2];
  logic [CNT_W-1:0]     lat     [2];
  logic                 val     [2];
  logic                 typ     [2];
  logic                 wt      [2];
  logic                 done    [2];
  logic [ADDR_BITS-1:0] idx     [2];
  logic [31:0]          wdata   [2];
  logic [31:0]          rdata   [2];
  logic [ADDR_BITS-1:0] init_idx;
  logic                 unused_addr_bits;

  assign val[0]   = mem0_val;
  assign val[1]   = mem1_val;
  assign typ[0]   = mem0_type;
  assign typ[1]   = mem1_type;
  assign idx[0]   = mem0_addr[ADDR_BITS+1:2];
  assign idx[1]   = mem1_addr[ADDR_BITS+1:2];
  assign init_idx = init_addr[ADDR_BITS+1:2];
  assign wdata[0] = mem0_wdata;
  assign wdata[1] = mem1_wdata;

  // Byte offset and bits above the array are ignored, so addresses wrap.
  assign unused_addr_bits = ^{mem0_addr[31:ADDR_BITS+2], mem0_addr[1:0],
                              mem1_addr[31:ADDR_BITS+2], mem1_addr[1:0],
                              init_addr[31:ADDR_BITS+2], init_addr[1:0]};

`ifdef MEM_RESPONDER_STALL_RAND_EN
  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  localparam logic [7:0] SEED1 = bit_rev8(LFSR_SEED);

  logic [7:0] lfsr_q [2];

  // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q[0] <= LFSR_SEED;
      lfsr_q[1] <= SEED1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        lfsr_q[p] <= {lfsr_q[p][6:0],
                      lfsr_q[p][7] ^ lfsr_q[p][5] ^ lfsr_q[p][4] ^ lfsr_q[p][3]};
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) lat[p] = LAT_C + CNT_W'(lfsr_q[p][1:0]);
  end
`else
  always_comb begin
    for (int p = 0; p < 2; p++) lat[p] = LAT_C;
  end
`endif

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        state_q[p] <= IDLE;
        cnt_q[p]   <= '0;
      end else begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      wt[p]      = 1'b0;
      done[p]    = 1'b0;
      if (rst) begin
        wt[p] = val[p];
      end else begin
        unique case (state_q[p])
          IDLE: begin
            if (val[p]) begin
              if (lat[p] == '0) begin
                done[p] = 1'b1;
              end else begin
                wt[p]      = 1'b1;
                state_d[p] = BUSY;
                cnt_d[p]   = lat[p] - CNT_W'(1);
              end
            end
          end
          BUSY: begin
            if (!val[p]) begin
              state_d[p] = IDLE;
              cnt_d[p]   = '0;
            end else if (cnt_q[p] != '0) begin
              wt[p]    = 1'b1;
              cnt_d[p] = cnt_q[p] - CNT_W'(1);
            end else begin
              done[p]    = 1'b1;
              state_d[p] = IDLE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) rdata[p] = (done[p] && !typ[p]) ? mem[idx[p]] : '0;
  end

  // Later assignments win on a shared index: init over mem1 over mem0.
  always_ff @(posedge clk) begin
    if (done[0] && typ[0]) mem[idx[0]] <= wdata[0];
    if (done[1] && typ[1]) mem[idx[1]] <= wdata[1];
    if (init_en)           mem[init_idx] <= init_wdata;
  end

  assign mem0_wait  = wt[0];
  assign mem1_wait  = wt[1];
  assign mem0_rdata = rdata[0];
  assign mem1_rdata = rdata[1];

endmodule

// File: tb/tb_mem_responder_2port.sv
// Bench for mem_responder_2port: four instances with LATENCY 0..3, directed table, corner sequences,
// and randomized paired traffic checked against a transaction-level memory model.
module tb_mem_responder_2port;

  localparam logic [7:0] SEED = 8'hA5;

  typedef struct {
    logic        val;
    logic        typ;
    logic [31:0] addr;
    logic [31:0] wdata;
  } pin_t;

  typedef struct {
    int          g;
    int          p;
    logic        typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  pin_t        pin   [4][2];
  logic        pw    [4][2];
  logic [31:0] prd   [4][2];
  logic        ien   [4];
  logic [31:0] iaddr [4];
  logic [31:0] iwd   [4];
  logic [31:0] model [4][1024];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Cycles since the last reset edge; the stall LFSR state is a function of this.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder_2port #(.ADDR_BITS(10), .LATENCY(g), .LFSR_SEED(SEED)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .mem0_val   (pin[g][0].val),
      .mem0_wait  (pw[g][0]),
      .mem0_type  (pin[g][0].typ),
      .mem0_addr  (pin[g][0].addr),
      .mem0_wdata (pin[g][0].wdata),
      .mem0_rdata (prd[g][0]),
      .mem1_val   (pin[g][1].val),
      .mem1_wait  (pw[g][1]),
      .mem1_type  (pin[g][1].typ),
      .mem1_addr  (pin[g][1].addr),
      .mem1_wdata (pin[g][1].wdata),
      .mem1_rdata (prd[g][1]),
      .init_en    (ien[g]),
      .init_addr  (iaddr[g]),
      .init_wdata (iwd[g])
    );
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Expected wait cycles for a request first presented in cycle c on instance g (LATENCY = g).
  function automatic int exp_lat(int g, int p, int c);
    int e = g;
`ifdef MEM_RESPONDER_STALL_RAND_EN
    logic [7:0] l;
    logic [7:0] s;
    s = SEED;
    for (int i = 0; i < 8; i++) l[i] = (p == 0) ? s[i] : s[7-i];
    for (int k = 0; k < c; k++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    e = e + int'(l[1:0]);
`else
    if (p < 0) e = -1;
`endif
    return e;
  endfunction

  // Starts and ends just after a rising edge; counts wait cycles, captures completion data.
  task automatic txn(input int g, input int p, input logic typ, input logic [31:0] a,
                     input logic [31:0] d, output int nwait, output logic [31:0] rd,
                     output int start_c, output int done_c);
    pin[g][p].val   = 1'b1;
    pin[g][p].typ   = typ;
    pin[g][p].addr  = a;
    pin[g][p].wdata = d;
    start_c = cyc;
    nwait   = 0;
    rd      = '0;
    done_c  = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!pw[g][p]) begin
        rd     = prd[g][p];
        done_c = cyc;
        break;
      end
      check("rdata_zero_while_waiting", prd[g][p], 32'h0);
      nwait++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    pin[g][p].val = 1'b0;
    if (done_c < 0) nwait = -1;
  endtask

  task automatic rd_chk(input int g, input int p, input logic [31:0] a,
                        input logic [31:0] exp, input string name);
    int w, s, c;
    logic [31:0] rd;
    txn(g, p, 1'b0, a, 32'h0, w, rd, s, c);
    check({name, "_wait"}, w, exp_lat(g, p, s));
    check({name, "_rdata"}, rd, exp);
  endtask

  task automatic init_write(input int g, input logic [31:0] a, input logic [31:0] d);
    ien[g] = 1'b1; iaddr[g] = a; iwd[g] = d;
    @(posedge clk); #1;
    ien[g] = 1'b0;
    model[g][widx(a)] = d;
  endtask

  // Both ports issue together; the model applies completions in cycle order, mem1 over mem0 on ties.
  task automatic pair(input int g, input logic t0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic t1, input logic [31:0] a1, input logic [31:0] d1);
    int w0, w1, s0, s1, c0, c1;
    logic [31:0] r0, r1;
    fork
      txn(g, 0, t0, a0, d0, w0, r0, s0, c0);
      txn(g, 1, t1, a1, d1, w1, r1, s1, c1);
    join
    check("pair_wait0", w0, exp_lat(g, 0, s0));
    check("pair_wait1", w1, exp_lat(g, 1, s1));
    if (c1 < c0) begin
      if (!t1) check("pair_rdata1", r1, model[g][widx(a1)]);
      if (t1)  model[g][widx(a1)] = d1;
      if (!t0) check("pair_rdata0", r0, model[g][widx(a0)]);
      if (t0)  model[g][widx(a0)] = d0;
    end else begin
      if (!t0) check("pair_rdata0", r0, model[g][widx(a0)]);
      if (t0 && c0 < c1) model[g][widx(a0)] = d0;
      if (!t1) check("pair_rdata1", r1, model[g][widx(a1)]);
      if (t0 && c0 == c1) model[g][widx(a0)] = d0;
      if (t1)  model[g][widx(a1)] = d1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [10];
    int w, s, c;
    logic [31:0] rd, tmp, a0, a1;

    vt[0] = '{3, 1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
    vt[1] = '{3, 1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
    vt[2] = '{3, 0, 1'b0, 32'h0000_0102, 32'h0,         32'hDEAD_BEEF};
    vt[3] = '{3, 0, 1'b0, 32'h8000_0100, 32'h0,         32'hDEAD_BEEF};
    vt[4] = '{0, 1, 1'b1, 32'h0000_1000, 32'h0000_0055, 32'h0};
    vt[5] = '{0, 0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0055};
    vt[6] = '{0, 0, 1'b1, 32'h0000_0304, 32'hCAFE_F00D, 32'h0};
    vt[7] = '{0, 1, 1'b0, 32'hFFFF_F304, 32'h0,         32'hCAFE_F00D};
    vt[8] = '{1, 0, 1'b1, 32'h0000_0008, 32'hA5A5_0001, 32'h0};
    vt[9] = '{1, 1, 1'b0, 32'h0000_000B, 32'h0,         32'hA5A5_0001};

    for (int g = 0; g < 4; g++) begin
      ien[g] = 1'b0; iaddr[g] = '0; iwd[g] = '0;
      for (int p = 0; p < 2; p++) pin[g][p] = '{1'b0, 1'b0, 32'h0, 32'h0};
      for (int i = 0; i < 1024; i++) model[g][i] = '0;
    end

    // Reset: wait mirrors val, rdata stays zero.
    pin[0][0].val = 1'b1;
    pin[3][1].val = 1'b1; pin[3][1].typ = 1'b1; pin[3][1].wdata = 32'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wait_eq_val0", pw[0][0], 1'b1);
    check("rst_rdata0", prd[0][0], 32'h0);
    check("rst_wait_idle", pw[0][1], 1'b0);
    check("rst_wait_write", pw[3][1], 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    pin[0][0].val = 1'b0;
    pin[3][1].val = 1'b0;
    @(posedge clk); #1;

    // Fetch after init preload, zero latency.
    init_write(0, 32'h200, 32'h0000_0013);
    rd_chk(0, 0, 32'h200, 32'h0000_0013, "fetch_lat0");

    for (int i = 0; i < 10; i++) begin
      txn(vt[i].g, vt[i].p, vt[i].typ, vt[i].addr, vt[i].wdata, w, rd, s, c);
      check($sformatf("vec%0d_wait", i), w, exp_lat(vt[i].g, vt[i].p, s));
      if (!vt[i].typ) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      else            model[vt[i].g][widx(vt[i].addr)] = vt[i].wdata;
    end

    // Parallel reads on LATENCY=2, then an abort on port 1.
    init_write(2, 32'h000, 32'h1111_0000);
    init_write(2, 32'h004, 32'h2222_0004);
    pair(2, 1'b0, 32'h000, 32'h0, 1'b0, 32'h004, 32'h0);
    pin[2][1].val = 1'b1; pin[2][1].typ = 1'b1;
    pin[2][1].addr = 32'h004; pin[2][1].wdata = 32'h3333_3333;
    @(negedge clk);
    check("abort_busy_wait", pw[2][1], 1'b1);
    @(posedge clk); #1;
    pin[2][1].val = 1'b0;
    @(negedge clk);
    check("abort_idle_wait", pw[2][1], 1'b0);
    @(posedge clk); #1;
    rd_chk(2, 1, 32'h004, 32'h2222_0004, "abort_no_write");

    // Same-index write priority and read-during-write.
`ifndef MEM_RESPONDER_STALL_RAND_EN
    fork
      begin
        ien[0] = 1'b1; iaddr[0] = 32'h40; iwd[0] = 32'h1;
        @(posedge clk); #1;
        ien[0] = 1'b0;
      end
      pair(0, 1'b1, 32'h40, 32'h3, 1'b1, 32'h40, 32'h2);
    join
    model[0][widx(32'h40)] = 32'h1;
    rd_chk(0, 0, 32'h40, 32'h1, "prio_init_wins");
`endif
    pair(0, 1'b1, 32'h40, 32'h3, 1'b1, 32'h40, 32'h2);
    rd_chk(0, 0, 32'h40, 32'h2, "prio_mem1_wins");
    pair(0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h40, 32'h7);
    rd_chk(0, 1, 32'h40, 32'h7, "rdw_new_value");

    // Reset in the middle of a LATENCY=3 write; init still commits during reset.
    init_write(3, 32'h80, 32'h0000_0011);
    pin[3][1].val = 1'b1; pin[3][1].typ = 1'b1;
    pin[3][1].addr = 32'h80; pin[3][1].wdata = 32'h0000_0099;
    @(negedge clk);
    check("pre_rst_busy", pw[3][1], 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    pin[3][0].val = 1'b1; pin[3][0].typ = 1'b0; pin[3][0].addr = 32'h80;
    ien[3] = 1'b1; iaddr[3] = 32'h84; iwd[3] = 32'h0000_0022;
    @(negedge clk);
    check("midrst_wait1", pw[3][1], 1'b1);
    check("midrst_wait0", pw[3][0], 1'b1);
    check("midrst_rdata0", prd[3][0], 32'h0);
    check("midrst_rdata1", prd[3][1], 32'h0);
    @(posedge clk); #1;
    ien[3] = 1'b0;
    pin[3][0].val = 1'b0;
    @(negedge clk);
    check("midrst_wait0_low", pw[3][0], 1'b0);
    check("midrst_wait1_held", pw[3][1], 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    pin[3][1].val = 1'b0;
    model[3][widx(32'h84)] = 32'h0000_0022;
    @(posedge clk); #1;
    rd_chk(3, 0, 32'h80, 32'h0000_0011, "rst_write_dropped");
    rd_chk(3, 1, 32'h84, 32'h0000_0022, "init_during_rst");

    // 50 held reads on port 1, LATENCY=1.
    init_write(1, 32'h0, 32'h0BAD_F00D);
    for (int i = 0; i < 50; i++) begin
      txn(1, 1, 1'b0, 32'h0, 32'h0, w, rd, s, c);
      check("held_run_len", w, exp_lat(1, 1, s));
      check("held_run_range", (w >= 1 && w <= 4), 1'b1);
      check("held_rdata", rd, 32'h0BAD_F00D);
    end

    // Randomized paired traffic on LATENCY 0 and 2.
    for (int i = 0; i < 8; i++) begin
      init_write(0, 32'(i * 4), $urandom);
      init_write(2, 32'(i * 4), $urandom);
    end
    for (int it = 0; it < 80; it++) begin
      tmp = $urandom;
      a0  = (tmp & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
      tmp = $urandom;
      a1  = (tmp & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
      pair((it % 2 == 0) ? 0 : 2, 1'($urandom_range(0, 1)), a0, $urandom,
           1'($urandom_range(0, 1)), a1, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder_2port.md
Name: mem_responder_2port

Overview:
- Synthesizable two-port memory responder; the responder end of the val/wait memory protocol that the processor initiates on its imem and dmem ports.
- Port 0 serves instruction fetch (read-only use); port 1 serves data (read/write).
- A word array backs both ports. Each port has its own wait-state FSM with configurable latency.
- A backdoor init port preloads programs and data in FPGA and bench builds.

Parameters:
- ADDR_BITS, 10, log2 of word count (1024 words = 4 KB).
- LATENCY, 0, fixed wait cycles per transaction, range 0..15.
- LFSR_SEED, 8'hA5, nonzero reset seed for the optional stall LFSRs.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem0_val  in  1  port 0 request valid
- mem0_wait  out  1  port 0 not-complete this cycle
- mem0_type  in  1  0=read, 1=write
- mem0_addr  in  32  byte address
- mem0_wdata  in  32  write data
- mem0_rdata  out  32  read data
- mem1_val/mem1_wait/mem1_type/mem1_addr/mem1_wdata/mem1_rdata  same as port 0, for port 1
- init_en  in  1  backdoor write enable
- init_addr  in  32  backdoor byte address
- init_wdata  in  32  backdoor write data

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Protocol: a transaction completes in a cycle where val=1 and wait=0. The initiator holds type/addr/wdata stable while wait=1.
- Read data: rdata is valid combinationally in the completion cycle. rdata=0 in all other cycles.
- Writes: a write commits at the rising edge that ends the completion cycle.
- Indexing: index = addr[ADDR_BITS+1:2]. addr[1:0] and the upper bits are ignored, so out-of-range addresses wrap.
- Per-port FSM: states IDLE and BUSY, plus a 4-bit counter cnt.
  - IDLE, val=0: wait=0.
  - IDLE, val=1, LATENCY=0: wait=0; transaction completes this cycle.
  - IDLE, val=1, LATENCY>0: wait=1; go to BUSY with cnt=LATENCY-1.
  - BUSY, val=1, cnt>0: wait=1; cnt decrements.
  - BUSY, val=1, cnt=0: wait=0; transaction completes; return to IDLE.
  - BUSY, val=0: abort; go to IDLE with no write.
- Latency: exactly LATENCY wait cycles, so a request first seen in cycle T completes in cycle T+LATENCY.
- Back-to-back: after a completion the FSM is in IDLE, so a held val starts a new transaction next cycle with full latency. LATENCY=0 gives one transaction per cycle.
- Ports are independent: one may be BUSY while the other completes.
- Write priority, same index, same edge: init > mem1 > mem0.
- Read during write: a read completing in the same cycle as a write to the same index returns the old data.
- Reset:
  - FSMs go to IDLE with cnt=0; LFSRs load LFSR_SEED.
  - While rst=1: waitN=valN, rdata=0, and no port writes commit.
  - init writes do commit during reset.
  - Array contents are not cleared.
  - Reset mid-transaction aborts the transaction; a write in flight is dropped.
- Waveform note: mem0_type=1 is honoured (no read-only enforcement).

Optional Feature:
- Macro: MEM_RESPONDER_STALL_RAND_EN.
- When defined:
  - Each port has an 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every cycle.
  - On IDLE with val=1, the port's latency is LATENCY + lfsr[1:0], giving 0..3 extra wait cycles.
  - A total of 0 completes immediately.
  - Port 0 uses LFSR_SEED; port 1 uses LFSR_SEED with bits reversed.
- When undefined: no LFSR logic; latency is exactly LATENCY.

Test Plan:
1. Init writes 0x00000013 to addr 0x200. With LATENCY=0, mem0 reads 0x200 → wait=0 in the same cycle, rdata=0x00000013.
2. LATENCY=3: mem1 writes 0xDEADBEEF to 0x100, held → wait=1 for 3 cycles, completes in the 4th. A following read of 0x100 returns 0xDEADBEEF after 3 more wait cycles.
3. LATENCY=2: mem0 reads 0x000 and mem1 reads 0x004 from the same cycle → both complete in cycle T+2 with correct data. Then mem1 drops val while BUSY → FSM returns to IDLE and no write commits.
4. Same-cycle writes to 0x40: init=0x1, mem1=0x2, mem0=0x3 → readback 0x1. Repeat without init → readback 0x2. A mem0 read of 0x40 in the same cycle as a mem1 write returns the old value.
5. Wrap and reset:
   - ADDR_BITS=10: write 0x55 at 0x1000, read 0x0000 → 0x55.
   - Assert rst during a LATENCY=3 write, then release → data unchanged; wait=val during reset; rdata=0 during reset.
6. With MEM_RESPONDER_STALL_RAND_EN and LATENCY=1: issue 50 held mem1 reads → every wait-run length is in 1..4, and the run-length sequence matches the golden LFSR model seeded 0xA5 (reversed).
